// File: rtl/csr_file.sv
// CSR file for the WB stage: software CSR access, exception/ertn commit,
// the stable-counter timer and interrupt aggregation for the front end.
`timescale 1ns/1ps
module csr_file #(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);

  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_BADV   = 14'h07;
  localparam logic [13:0] A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  localparam logic [5:0] ECODE_ADE = 6'h8;
  localparam logic [5:0] ECODE_ALE = 6'h9;

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wv,
                                         input logic [31:0] wm);
    return (old & ~wm) | (wv & wm);
  endfunction

  // CRMD and PRMD share the {IE, PLV[1:0]} layout, so exception/ertn copy them whole.
  logic [2:0]         crmd_reg;
  logic [2:0]         prmd_reg;
  logic [12:0]        ecfg_reg;
  logic [1:0]         estat_sw_reg;
  logic [7:0]         estat_hw_reg;
  logic               estat_ti_reg;
  logic               estat_ipi_reg;
  logic [5:0]         ecode_reg;
  logic [8:0]         esubcode_reg;
  logic [31:0]        era_reg;
  logic [31:0]        badv_reg;
  logic [25:0]        eentry_reg;
  logic [31:0]        tid_reg;
  logic [31:0]        tcfg_reg;
  logic [TIMER_W-1:0] tval_reg;
  logic [3:0][31:0]   save_q;

  logic [31:0] crmd_val, prmd_val, ecfg_val, estat_val, eentry_val;
  assign crmd_val   = {28'b0, 1'b1, crmd_reg};
  assign prmd_val   = {29'b0, prmd_reg};
  assign ecfg_val   = {19'b0, ecfg_reg};
  assign estat_val  = {1'b0, esubcode_reg, ecode_reg, 3'b0, estat_ipi_reg, estat_ti_reg,
                       1'b0, estat_hw_reg, estat_sw_reg};
  assign eentry_val = {eentry_reg, 6'b0};

  logic wr_en;
  logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv, we_eentry;
  logic we_tid, we_tcfg, we_ticlr;
  assign wr_en     = csr_we & ~wb_ex;
  assign we_crmd   = wr_en & ~ertn_flush & (csr_num == A_CRMD);
  assign we_prmd   = wr_en & (csr_num == A_PRMD);
  assign we_ecfg   = wr_en & (csr_num == A_ECFG);
  assign we_estat  = wr_en & (csr_num == A_ESTAT);
  assign we_era    = wr_en & (csr_num == A_ERA);
  assign we_badv   = wr_en & (csr_num == A_BADV);
  assign we_eentry = wr_en & (csr_num == A_EENTRY);
  assign we_tid    = wr_en & (csr_num == A_TID);
  assign we_tcfg   = wr_en & (csr_num == A_TCFG);
  assign we_ticlr  = wr_en & (csr_num == A_TICLR);

  logic [31:0]        tcfg_wr;
  logic               timer_fire;
  logic [TIMER_W-1:0] tval_reload;
  assign tcfg_wr     = wmerge(tcfg_reg, csr_wvalue, csr_wmask);
  assign timer_fire  = tcfg_reg[0] && (tval_reg == '0);
  assign tval_reload = {tcfg_reg[TIMER_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crmd_reg <= 3'b0;
      prmd_reg <= 3'b0;
    end else begin
      if (wb_ex) begin
        prmd_reg <= crmd_reg;
        crmd_reg <= 3'b0;
      end else begin
        if (ertn_flush)   crmd_reg <= prmd_reg;
        else if (we_crmd) crmd_reg <= 3'(wmerge(crmd_val, csr_wvalue, csr_wmask));
        if (we_prmd)      prmd_reg <= 3'(wmerge(prmd_val, csr_wvalue, csr_wmask));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecfg_reg     <= 13'b0;
      estat_sw_reg <= 2'b0;
      estat_hw_reg <= 8'b0;
      estat_ti_reg <= 1'b0;
      estat_ipi_reg <= 1'b0;
      ecode_reg    <= 6'b0;
      esubcode_reg <= 9'b0;
    end else begin
      estat_hw_reg  <= hw_int_in;
      estat_ipi_reg <= ipi_int_in;
      if (we_ecfg)
        ecfg_reg <= 13'(wmerge(ecfg_val, csr_wvalue, csr_wmask)) & ~13'h400;
      if (we_estat)
        estat_sw_reg <= 2'(wmerge(estat_val, csr_wvalue, csr_wmask));
      // A timer fire in the same cycle as a TICLR write leaves the interrupt pending.
      if (timer_fire)
        estat_ti_reg <= 1'b1;
      else if (we_ticlr && csr_wmask[0] && csr_wvalue[0])
        estat_ti_reg <= 1'b0;
      if (wb_ex) begin
        ecode_reg    <= wb_ecode;
        esubcode_reg <= wb_esubcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      era_reg    <= 32'b0;
      badv_reg   <= 32'b0;
      eentry_reg <= 26'b0;
      tid_reg    <= TID_RST;
    end else begin
      if (wb_ex)       era_reg <= wb_pc;
      else if (we_era) era_reg <= wmerge(era_reg, csr_wvalue, csr_wmask);
      if (wb_ex && wb_ecode == ECODE_ALE)      badv_reg <= wb_vaddr;
      else if (wb_ex && wb_ecode == ECODE_ADE) badv_reg <= wb_pc;
      else if (we_badv)                        badv_reg <= wmerge(badv_reg, csr_wvalue, csr_wmask);
      if (we_eentry) eentry_reg <= 26'(wmerge(eentry_val, csr_wvalue, csr_wmask) >> 6);
      if (we_tid)    tid_reg <= wmerge(tid_reg, csr_wvalue, csr_wmask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcfg_reg <= 32'b0;
      tval_reg <= '0;
    end else begin
      if (timer_fire) begin
        if (tcfg_reg[1]) tval_reg <= tval_reload;
        else             tcfg_reg[0] <= 1'b0;
      end else if (tcfg_reg[0]) begin
        tval_reg <= tval_reg - 1'b1;
      end
      // A software TCFG write overrides this cycle's countdown/reload.
      if (we_tcfg) begin
        tcfg_reg <= tcfg_wr;
        if (tcfg_wr[0]) tval_reg <= {tcfg_wr[TIMER_W-1:2], 2'b00};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_save
      logic [31:0] save_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          save_reg <= 32'b0;
        else if (wr_en && csr_num == A_SAVE0 + 14'(gi))
          save_reg <= wmerge(save_reg, csr_wvalue, csr_wmask);
      end
      assign save_q[gi] = save_reg;
    end
  endgenerate

  always_comb begin
    csr_rvalue = 32'b0;
    case (csr_num)
      A_CRMD:         csr_rvalue = crmd_val;
      A_PRMD:         csr_rvalue = prmd_val;
      A_ECFG:         csr_rvalue = ecfg_val;
      A_ESTAT:        csr_rvalue = estat_val;
      A_ERA:          csr_rvalue = era_reg;
      A_BADV:         csr_rvalue = badv_reg;
      A_EENTRY:       csr_rvalue = eentry_val;
      A_SAVE0:        csr_rvalue = save_q[0];
      A_SAVE0 + 14'd1: csr_rvalue = save_q[1];
      A_SAVE0 + 14'd2: csr_rvalue = save_q[2];
      A_SAVE0 + 14'd3: csr_rvalue = save_q[3];
      A_TID:          csr_rvalue = tid_reg;
      A_TCFG:         csr_rvalue = tcfg_reg;
      A_TVAL:         csr_rvalue = 32'(tval_reg);
      default:        csr_rvalue = 32'b0;
    endcase
  end

  assign has_int    = crmd_reg[2] & (|(estat_val[12:0] & ecfg_reg));
  assign ex_entry   = eentry_val;
  assign ertn_entry = era_reg;

  // Read data is always presented, so the read strobe carries no information here.
  logic unused_re;
  assign unused_re = csr_re;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected read data, a negedge
// monitor pops and compares whenever a read transaction is presented.
`timescale 1ns/1ps
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex, ertn_flush;
  logic [31:0] wb_pc, wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry, ertn_entry;

  always #5 clk = ~clk;

  csr_file dut (
    .clk(clk), .rst(rst), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
  );

  localparam logic [13:0] CRMD = 14'h00, PRMD = 14'h01, ECFG = 14'h04, ESTAT = 14'h05;
  localparam logic [13:0] ERA = 14'h06, BADV = 14'h07, EENTRY = 14'h0C;
  localparam logic [13:0] SAVE0 = 14'h30, SAVE1 = 14'h31, SAVE2 = 14'h32;
  localparam logic [13:0] TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;
  localparam logic [13:0] NOMAP = 14'h10;

  // kind: 0 = csr_rvalue, 1 = ex_entry, 2 = ertn_entry
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    bit          chk_int;
    logic        int_exp;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  item_t cur;
  logic [31:0] got;

  always @(negedge clk) begin
    if (csr_re) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_read num=%0h actual=%08h required=no-read", csr_num, csr_rvalue);
      end else begin
        cur = sb.pop_front();
        got = (cur.kind == 1) ? ex_entry : (cur.kind == 2) ? ertn_entry : csr_rvalue;
        n_cmp++;
        if (got !== cur.exp) begin
          n_bad++;
          $display("FAIL %s actual=%08h required=%08h", cur.name, got, cur.exp);
        end else if (cur.chk_int) begin
          $display("rd %-14s got=%08h has_int=%0b", cur.name, got, has_int);
        end else begin
          $display("rd %-14s got=%08h", cur.name, got);
        end
        if (cur.chk_int) begin
          n_cmp++;
          if (has_int !== cur.int_exp) begin
            n_bad++;
            $display("FAIL %s_has_int actual=%0b required=%0b", cur.name, has_int, cur.int_exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    csr_re = 1'b0; csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
    csr_num = 14'h0; csr_wmask = 32'h0; csr_wvalue = 32'h0;
  endtask

  task automatic issue(input logic [13:0] num, input int kind, input logic [31:0] exp,
                       input bit ci, input logic ie, input string nm);
    item_t it;
    it.name = nm; it.kind = kind; it.exp = exp; it.chk_int = ci; it.int_exp = ie;
    csr_re  = 1'b1;
    csr_num = num;
    sb.push_back(it);
  endtask

  task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string nm);
    step();
    issue(num, 0, exp, 1'b0, 1'b0, nm);
  endtask

  task automatic rdi(input logic [13:0] num, input logic [31:0] exp, input logic ie,
                     input string nm);
    step();
    issue(num, 0, exp, 1'b1, ie, nm);
  endtask

  task automatic chk_out(input int kind, input logic [31:0] exp, input string nm);
    step();
    issue(NOMAP, kind, exp, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    step();
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
  endtask

  task automatic exc(input logic [31:0] pc, input logic [5:0] ec, input logic [8:0] esc,
                     input logic [31:0] va);
    step();
    wb_ex = 1'b1; wb_pc = pc; wb_ecode = ec; wb_esubcode = esc; wb_vaddr = va;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; csr_re = 1'b0; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0;
    csr_wvalue = 32'h0; wb_ex = 1'b0; ertn_flush = 1'b0; wb_pc = 32'h0; wb_vaddr = 32'h0;
    wb_ecode = 6'h0; wb_esubcode = 9'h0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    rdi(CRMD, 32'h8, 1'b0, "reset_crmd");
    rd(TID, 32'h0, "reset_tid");
    rd(TVAL, 32'h0, "reset_tval");
    chk_out(1, 32'h0, "reset_ex_entry");
    chk_out(2, 32'h0, "reset_ertn_entry");

    // Masked writes and field restrictions
    wr(SAVE2, 32'hFFFF_0000, 32'hDEAD_BEEF);
    rd(SAVE2, 32'hDEAD_0000, "save2_masked");
    wr(NOMAP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(NOMAP, 32'h0, "unmapped");
    wr(ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(ESTAT, 32'h3, "estat_sw_only");
    wr(ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(ECFG, 32'h0000_1BFF, "ecfg_fields");
    wr(ECFG, 32'hFFFF_FFFF, 32'h0);
    wr(ESTAT, 32'h3, 32'h0);
    rd(ESTAT, 32'h0, "estat_cleared");
    wr(EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(EENTRY, 32'hFFFF_FFC0, "eentry_fields");
    chk_out(1, 32'hFFFF_FFC0, "ex_entry");
    wr(TVAL, 32'hFFFF_FFFF, 32'h1234);
    rd(TVAL, 32'h0, "tval_readonly");
    wr(TID, 32'hFFFF_FFFF, 32'h0000_A5A5);
    rd(TID, 32'h0000_A5A5, "tid_write");
    wr(PRMD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(PRMD, 32'h7, "prmd_fields");
    wr(PRMD, 32'hFFFF_FFFF, 32'h0);

    // Exception (ALE) and ertn; ertn does not block an unrelated CSR write
    wr(CRMD, 32'hFFFF_FFFF, 32'h7);
    rd(CRMD, 32'hF, "crmd_write");
    rd(PRMD, 32'h0, "prmd_before_ex");
    exc(32'h1C00_0100, 6'h9, 9'h0, 32'h33);
    rd(CRMD, 32'h8, "ex_crmd");
    rd(PRMD, 32'h7, "ex_prmd");
    rd(ERA, 32'h1C00_0100, "ex_era");
    rd(BADV, 32'h33, "ex_badv_ale");
    rd(ESTAT, 32'h0009_0000, "ex_estat");
    chk_out(2, 32'h1C00_0100, "ertn_entry");
    step();
    ertn_flush = 1'b1; csr_we = 1'b1; csr_num = SAVE1; csr_wmask = 32'hFFFF_FFFF;
    csr_wvalue = 32'h1234;
    rd(CRMD, 32'hF, "ertn_crmd");
    rd(SAVE1, 32'h1234, "ertn_save1_wr");

    // ADE takes BADV from the PC
    exc(32'h1C00_0200, 6'h8, 9'h0, 32'h55);
    rd(BADV, 32'h1C00_0200, "ex_badv_ade");
    rd(PRMD, 32'h7, "ade_prmd");

    // Exception drops a simultaneous CSR write; other ecode leaves BADV alone
    exc(32'h1C00_0300, 6'hB, 9'h1, 32'h77);
    csr_we = 1'b1; csr_num = SAVE0; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h5;
    rd(SAVE0, 32'h0, "ex_drops_we");
    rd(ERA, 32'h1C00_0300, "ex2_era");
    rd(BADV, 32'h1C00_0200, "badv_hold");
    rd(ESTAT, 32'h004B_0000, "ex2_estat");
    rd(PRMD, 32'h0, "ex2_prmd");

    // ertn protects CRMD from a same-cycle CRMD write
    step();
    ertn_flush = 1'b1; csr_we = 1'b1; csr_num = CRMD; csr_wmask = 32'hFFFF_FFFF;
    csr_wvalue = 32'h7;
    rd(CRMD, 32'h8, "ertn_blocks_crmd");
    wr(CRMD, 32'h7, 32'h4);
    rd(CRMD, 32'hC, "crmd_ie");

    // One-shot timer
    wr(ECFG, 32'hFFFF_FFFF, 32'h800);
    wr(TCFG, 32'hFFFF_FFFF, 32'h11);
    for (int i = 16; i >= 0; i--) begin
      if (i == 0) rdi(TVAL, 32'(i), 1'b0, "oneshot_tval0");
      else        rd(TVAL, 32'(i), $sformatf("oneshot_tval%0d", i));
    end
    rdi(ESTAT, 32'h004B_0800, 1'b1, "oneshot_fire");
    rd(TCFG, 32'h10, "oneshot_en_clr");
    rd(TVAL, 32'h0, "oneshot_hold0");
    wr(TICLR, 32'h1, 32'h1);
    rdi(ESTAT, 32'h004B_0000, 1'b0, "ticlr_clear");
    rd(TICLR, 32'h0, "ticlr_reads0");

    // Periodic timer, period 5, with a TICLR collision
    wr(TCFG, 32'hFFFF_FFFF, 32'h7);
    for (int i = 4; i >= 1; i--) rd(TVAL, 32'(i), $sformatf("per_tval%0d", i));
    rdi(TVAL, 32'h0, 1'b0, "per_tval0");
    rdi(TVAL, 32'h4, 1'b1, "per_reload");
    for (int i = 3; i >= 1; i--) rd(TVAL, 32'(i), $sformatf("per2_tval%0d", i));
    wr(TICLR, 32'h1, 32'h1);
    rdi(ESTAT, 32'h004B_0800, 1'b1, "ticlr_vs_fire");
    wr(TICLR, 32'h1, 32'h1);
    rdi(ESTAT, 32'h004B_0000, 1'b0, "per_ticlr");
    wr(TCFG, 32'hFFFF_FFFF, 32'h0);

    // Hardware interrupt latency
    wr(ECFG, 32'hFFFF_FFFF, 32'h4);
    step();
    hw_int_in = 8'h01;
    issue(ESTAT, 0, 32'h004B_0000, 1'b1, 1'b0, "hw_same_cycle");
    rdi(ESTAT, 32'h004B_0004, 1'b1, "hw_next_cycle");
    step();
    hw_int_in = 8'h00;
    issue(ESTAT, 0, 32'h004B_0004, 1'b1, 1'b1, "hw_drop_same");
    rdi(ESTAT, 32'h004B_0000, 1'b0, "hw_drop_next");

    // Reset mid-count
    wr(TCFG, 32'hFFFF_FFFF, 32'h41);
    rd(TVAL, 32'd64, "run_tval64");
    rd(TVAL, 32'd63, "run_tval63");
    step();
    rst = 1'b0;
    issue(CRMD, 0, 32'h8, 1'b1, 1'b0, "rst_crmd");
    step();
    issue(TVAL, 0, 32'h0, 1'b0, 1'b0, "rst_tval");
    step();
    rst = 1'b1;
    issue(TCFG, 0, 32'h0, 1'b0, 1'b0, "rst_tcfg");
    rd(TVAL, 32'h0, "post_rst_tval");
    rd(SAVE2, 32'h0, "post_rst_save2");
    rd(TID, 32'h0, "post_rst_tid");
    chk_out(1, 32'h0, "post_rst_ex_entry");

    step();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
